psum_accum_unit: RTL

Parametrised partial-sum accumulation stage sitting between the PE array output buffer and the external psum buffer path of the convolution datapath. It pairs each conv result word with an incoming psum word and combines them per lane with a selectable mode: pass, wrap-add, saturate-add or add+ReLU. Results are queued in an internal FWFT output FIFO. It generalises the single-lane, single-mode accumulate path to PAR lanes, selectable arithmetic and per-job length control with done signalling.

---
 rtl/psum_accum_unit_if.sv | 34 +++
 rtl/psum_accum_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/psum_accum_unit_if.sv
// Purpose: bundles the job-control, conv/psum input and output-FIFO signals of psum_accum_unit.
// Latency: none, wiring only.
// Backpressure: conv_ready/psum_ready gate the inputs; out_ren pops the FWFT output FIFO.
interface psum_accum_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PAR        = 1,
    parameter int LEN_WIDTH  = 8
);
    logic                        start;
    logic [1:0]                  mode;
    logic [LEN_WIDTH-1:0]        job_len;
    logic                        conv_valid;
    logic [PAR*DATA_WIDTH-1:0]   conv_din;
    logic                        conv_ready;
    logic                        psum_valid;
    logic [PAR*DATA_WIDTH-1:0]   psum_din;
    logic                        psum_ready;
    logic                        out_ren;
    logic [PAR*DATA_WIDTH-1:0]   out_dout;
    logic                        out_empty;
    logic                        out_full;
    logic                        busy;
    logic                        done;

    modport master (
        output start, mode, job_len, conv_valid, conv_din, psum_valid, psum_din, out_ren,
        input  conv_ready, psum_ready, out_dout, out_empty, out_full, busy, done
    );

    modport slave (
        input  start, mode, job_len, conv_valid, conv_din, psum_valid, psum_din, out_ren,
        output conv_ready, psum_ready, out_dout, out_empty, out_full, busy, done
    );
endinterface

// File: rtl/psum_accum_unit.sv
// Purpose: per-lane conv/psum combine (pass, wrap-add, sat-add, sat-add+ReLU) into an FWFT output FIFO.
// Latency: 2 cycles from input handshake to entry visible at out_dout.
// Backpressure: readies drop when FIFO plus pipeline register would exceed depth (same-cycle pop credited).
module psum_accum_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int PAR        = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               rst,
    psum_accum_unit_if.slave   bus
);
    localparam int W  = DATA_WIDTH;
    localparam int BW = PAR * DATA_WIDTH;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] acc_q, acc_d;
    logic                 pipe_vld_q, pipe_vld_d;
    logic [BW-1:0]        res_q, res_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [BW-1:0]        mem_q [FIFO_DEPTH];

    logic                 fifo_empty, push, pop, space, run, both_vld, xfer;
    logic [CW:0]          occ;
    logic [BW-1:0]        res_calc;
    logic [W-1:0]         lane_c, lane_p, lane_r;
    logic [W:0]           lane_s;

    // Flow control: occupancy counts the pipeline entry and credits this cycle's pop.
    always_comb begin
        fifo_empty = (cnt_q == '0);
        pop        = bus.out_ren && !fifo_empty;
        push       = pipe_vld_q;
        occ        = {1'b0, cnt_q} - (CW+1)'(pop) + (CW+1)'(pipe_vld_q);
        space      = (occ < (CW+1)'(FIFO_DEPTH));
        run        = (state_q == ST_RUN);
        both_vld   = bus.conv_valid && bus.psum_valid;
        if (mode_q == 2'd0) begin
            bus.conv_ready = run && space;
            bus.psum_ready = 1'b0;
        end else begin
            bus.conv_ready = run && space && both_vld;
            bus.psum_ready = run && space && both_vld;
        end
        xfer = bus.conv_valid && bus.conv_ready;
    end

    // Per-lane arithmetic; a W+1 bit sum exposes signed overflow for clamping.
    always_comb begin
        res_calc = '0;
        lane_c   = '0;
        lane_p   = '0;
        lane_r   = '0;
        lane_s   = '0;
        for (int k = 0; k < PAR; k++) begin
            lane_c = bus.conv_din[k*W +: W];
            lane_p = bus.psum_din[k*W +: W];
            lane_s = {lane_c[W-1], lane_c} + {lane_p[W-1], lane_p};
            case (mode_q)
                2'd0:    lane_r = lane_c;
                2'd1:    lane_r = lane_s[W-1:0];
                default: begin
                    if (lane_s[W] != lane_s[W-1])
                        lane_r = lane_s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                    else
                        lane_r = lane_s[W-1:0];
                    if (mode_q == 2'd3 && lane_r[W-1])
                        lane_r = '0;
                end
            endcase
            res_calc[k*W +: W] = lane_r;
        end
    end

    // Job FSM, pipeline register and FIFO pointer next-state.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        acc_d      = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    len_d   = bus.job_len;
                    acc_d   = '0;
                    state_d = (bus.job_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    acc_d = acc_q + LEN_WIDTH'(1);
                    if (acc_d == len_q)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pipe_vld_q)
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        pipe_vld_d = xfer;
        res_d      = xfer ? res_calc : res_q;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
    end

    // Control state with registered busy/done outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            pipe_vld_q <= 1'b0;
            res_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            pipe_vld_q <= pipe_vld_d;
            res_q      <= res_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= res_q;
    end

    assign bus.out_dout  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign bus.out_empty = fifo_empty;
    assign bus.out_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
